// File: rtl/uart_cmd_handler.sv
// UART command handler: collects a command/address byte pair, validates it,
// queries the sensor side and returns a two-byte response over the UART.
`timescale 1ns/1ps
module uart_cmd_handler #(
  parameter int         FRAME_TIMEOUT = 52080,
  parameter int         RSP_TIMEOUT   = 50000000,
  parameter logic [7:0] MAX_CMD       = 8'h06
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte,
  input  logic       i_Tx_Active,
  input  logic       i_Tx_Done,
  output logic       o_Req,
  output logic [7:0] o_Req_Cmd,
  output logic [4:0] o_Req_Addr,
  input  logic       i_Rsp_Valid,
  input  logic [7:0] i_Rsp_Data,
  input  logic       i_Rsp_Err,
  output logic       o_Busy,
  output logic       o_Drop,
  output logic [3:0] o_State
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    GET_ADDR = 4'd1,
    CHECK    = 4'd2,
    REQ      = 4'd3,
    WAIT_RSP = 4'd4,
    SEND0    = 4'd5,
    WAIT0    = 4'd6,
    SEND1    = 4'd7,
    WAIT1    = 4'd8
  } state_t;

  localparam int FW = $clog2(FRAME_TIMEOUT + 1);
  localparam int RW = $clog2(RSP_TIMEOUT + 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TIMEOUT - 1);
  localparam logic [FW-1:0] FRAME_MAX  = FW'(FRAME_TIMEOUT);
  localparam logic [RW-1:0] RSP_LAST   = RW'(RSP_TIMEOUT - 1);
  localparam logic [RW-1:0] RSP_MAX    = RW'(RSP_TIMEOUT);

  state_t        state;
  logic [7:0]    cmd;
  logic [7:0]    addr;
  logic [7:0]    byte0;
  logic [7:0]    byte1;
  logic [FW-1:0] frame_cnt;
  logic [RW-1:0] rsp_cnt;
  logic          busy;

  // Saturating increments: the counters stop at their limit instead of wrapping.
  function automatic logic [FW-1:0] frame_inc(input logic [FW-1:0] c);
    return (c >= FRAME_MAX) ? c : c + 1'b1;
  endfunction

  function automatic logic [RW-1:0] rsp_inc(input logic [RW-1:0] c);
    return (c >= RSP_MAX) ? c : c + 1'b1;
  endfunction

  assign busy    = (state != IDLE) && (state != GET_ADDR);
  assign o_Busy  = busy;
  assign o_State = state;

  // Main sequencer. A SENDx state is entered with o_Tx_DV already raised when
  // the transmitter is idle, so an error reply leaves one cycle after CHECK;
  // o_Tx_Byte is only reloaded on a launch, keeping it stable until i_Tx_Done.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state      <= IDLE;
      cmd        <= 8'h00;
      addr       <= 8'h00;
      byte0      <= 8'h00;
      byte1      <= 8'h00;
      frame_cnt  <= '0;
      rsp_cnt    <= '0;
      o_Tx_DV    <= 1'b0;
      o_Tx_Byte  <= 8'h00;
      o_Req      <= 1'b0;
      o_Req_Cmd  <= 8'h00;
      o_Req_Addr <= 5'h00;
      o_Drop     <= 1'b0;
    end else begin
      o_Tx_DV <= 1'b0;
      o_Drop  <= i_Rx_DV && busy;
      case (state)
        IDLE: begin
          if (i_Rx_DV) begin
            cmd       <= i_Rx_Byte;
            frame_cnt <= '0;
            state     <= GET_ADDR;
          end
        end
        GET_ADDR: begin
          if (i_Rx_DV) begin
            addr  <= i_Rx_Byte;
            state <= CHECK;
          end else if (frame_cnt >= FRAME_LAST) begin
            state <= IDLE;
          end else begin
            frame_cnt <= frame_inc(frame_cnt);
          end
        end
        CHECK: begin
          if (cmd > MAX_CMD || addr[7:5] != 3'b000) begin
            byte0 <= (cmd > MAX_CMD) ? 8'hE0 : 8'hE1;
            byte1 <= (cmd > MAX_CMD) ? cmd : addr;
            if (!i_Tx_Active) begin
              o_Tx_DV   <= 1'b1;
              o_Tx_Byte <= (cmd > MAX_CMD) ? 8'hE0 : 8'hE1;
            end
            state <= SEND0;
          end else begin
            o_Req      <= 1'b1;
            o_Req_Cmd  <= cmd;
            o_Req_Addr <= addr[4:0];
            rsp_cnt    <= '0;
            state      <= REQ;
          end
        end
        REQ: begin
          rsp_cnt <= rsp_inc(rsp_cnt);
          state   <= WAIT_RSP;
        end
        WAIT_RSP: begin
          if (i_Rsp_Valid || rsp_cnt >= RSP_LAST) begin
            o_Req <= 1'b0;
            if (i_Rsp_Valid && !i_Rsp_Err) begin
              byte0 <= 8'h80 | cmd;
              byte1 <= i_Rsp_Data;
            end else begin
              byte0 <= i_Rsp_Valid ? 8'hE2 : 8'hE3;
              byte1 <= 8'h00;
            end
            if (!i_Tx_Active) begin
              o_Tx_DV   <= 1'b1;
              o_Tx_Byte <= (i_Rsp_Valid && !i_Rsp_Err) ? (8'h80 | cmd) :
                           (i_Rsp_Valid ? 8'hE2 : 8'hE3);
            end
            state <= SEND0;
          end else begin
            rsp_cnt <= rsp_inc(rsp_cnt);
          end
        end
        SEND0: begin
          if (o_Tx_DV) begin
            state <= WAIT0;
          end else if (!i_Tx_Active) begin
            o_Tx_DV   <= 1'b1;
            o_Tx_Byte <= byte0;
          end
        end
        WAIT0: begin
          if (i_Tx_Done) begin
            if (!i_Tx_Active) begin
              o_Tx_DV   <= 1'b1;
              o_Tx_Byte <= byte1;
            end
            state <= SEND1;
          end
        end
        SEND1: begin
          if (o_Tx_DV) begin
            state <= WAIT1;
          end else if (!i_Tx_Active) begin
            o_Tx_DV   <= 1'b1;
            o_Tx_Byte <= byte1;
          end
        end
        WAIT1: begin
          if (i_Tx_Done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_handler.sv
// Bench for uart_cmd_handler: directed scenarios plus randomized frames
// checked against a response model built from the command/address rules.
`timescale 1ns/1ps
module tb_uart_cmd_handler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active;
  logic       tx_done;
  logic       req;
  logic [7:0] req_cmd;
  logic [4:0] req_addr;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;
  logic       drop;
  logic [3:0] state;

  logic       tx_act_model;
  logic       tx_hold;
  int         tx_len = 3;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int drop_cnt = 0;
  int req_rises = 0;
  int req_rise = 0;
  int req_fall = 0;
  logic req_prev = 1'b0;
  logic inflight = 1'b0;
  logic [7:0] held = 8'h00;
  logic [7:0] tx_log[$];

  assign tx_active = tx_act_model | tx_hold;

  uart_cmd_handler #(
    .FRAME_TIMEOUT(50),
    .RSP_TIMEOUT  (100),
    .MAX_CMD      (8'h06)
  ) dut (
    .i_Clock    (clk),
    .i_Rst_n    (rst_n),
    .i_Rx_DV    (rx_dv),
    .i_Rx_Byte  (rx_byte),
    .o_Tx_DV    (tx_dv),
    .o_Tx_Byte  (tx_byte),
    .i_Tx_Active(tx_active),
    .i_Tx_Done  (tx_done),
    .o_Req      (req),
    .o_Req_Cmd  (req_cmd),
    .o_Req_Addr (req_addr),
    .i_Rsp_Valid(rsp_valid),
    .i_Rsp_Data (rsp_data),
    .i_Rsp_Err  (rsp_err),
    .o_Busy     (busy),
    .o_Drop     (drop),
    .o_State    (state)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Transmitter model: busy for tx_len clocks after each launch, then a done pulse.
  initial begin
    tx_act_model = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_dv === 1'b1) begin
        @(posedge clk);
        #1 tx_act_model = 1'b1;
        repeat (tx_len - 1) @(posedge clk);
        #1 tx_done = 1'b1;
        tx_act_model = 1'b0;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  // Monitor: logs transmitted bytes, drop pulses and request edges.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      inflight = 1'b0;
    end else begin
      if (tx_dv === 1'b1) begin
        tx_log.push_back(tx_byte);
        held = tx_byte;
        inflight = 1'b1;
      end else if (tx_done && inflight) begin
        checks++;
        if (tx_byte !== held) begin
          errors++;
          $display("FAIL tx_byte_stable: got %02h expected %02h", tx_byte, held);
        end
        inflight = 1'b0;
      end
      if (drop === 1'b1) drop_cnt++;
      if (req === 1'b1 && !req_prev) begin
        req_rise = cyc;
        req_rises++;
      end
      if (req === 1'b0 && req_prev) req_fall = cyc;
    end
    req_prev = (req === 1'b1);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Expected {req_issued, byte0, byte1} for a frame, from the command rules.
  function automatic logic [16:0] model_rsp(input logic [7:0] c, input logic [7:0] a,
                                            input int kind, input logic [7:0] data);
    if (c > 8'h06) return {1'b0, 8'hE0, c};
    if (a > 8'd31) return {1'b0, 8'hE1, a};
    case (kind)
      0:       return {1'b1, 8'h80 | c, data};
      1:       return {1'b1, 8'hE2, 8'h00};
      default: return {1'b1, 8'hE3, 8'h00};
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_dv = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1 rx_dv = 1'b0;
  endtask

  // Response pulse sampled by the DUT d+2 edges after the request rose.
  task automatic pulse_rsp(input int d, input logic err, input logic [7:0] data);
    repeat (d + 1) @(posedge clk);
    #1 rsp_valid = 1'b1;
    rsp_err = err;
    rsp_data = data;
    @(posedge clk);
    #1 rsp_valid = 1'b0;
    rsp_err = 1'b0;
  endtask

  task automatic wait_done(input int n, input string name);
    int k;
    for (k = 0; k < 800; k++) begin
      @(negedge clk);
      if (tx_log.size() >= n && state == 4'd0) break;
    end
    checks++;
    if (k == 800) begin
      errors++;
      $display("FAIL %s_complete: %0d bytes sent, state %0d, required %0d bytes and idle",
               name, tx_log.size(), state, n);
    end
  endtask

  task automatic wait_req(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (req === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_log(input string name, input logic [7:0] b0, input logic [7:0] b1);
    checks++;
    if (tx_log.size() != 2 || tx_log[0] !== b0 || tx_log[1] !== b1) begin
      errors++;
      $display("FAIL %s_tx: got %0d bytes %02h %02h, expected 2 bytes %02h %02h",
               name, tx_log.size(), tx_log[0], tx_log[1], b0, b1);
    end
  endtask

  task automatic run_frame(input string name, input logic [7:0] c, input logic [7:0] a,
                           input int kind, input logic [7:0] data, input int d, input int gap);
    logic [16:0] exp;
    bit seen;
    exp = model_rsp(c, a, kind, data);
    tx_log.delete();
    send_byte(c);
    repeat (gap) @(posedge clk);
    send_byte(a);
    wait_req(seen);
    checks++;
    if (seen !== exp[16]) begin
      errors++;
      $display("FAIL %s_req: got %0b expected %0b", name, seen, exp[16]);
    end
    if (seen) begin
      checks++;
      if (req_cmd !== c || req_addr !== a[4:0]) begin
        errors++;
        $display("FAIL %s_req_fields: got cmd %02h addr %02h expected %02h %02h",
                 name, req_cmd, req_addr, c, a[4:0]);
      end
      if (kind == 0) pulse_rsp(d, 1'b0, data);
      else if (kind == 1) pulse_rsp(d, 1'b1, 8'($urandom));
    end
    wait_done(2, name);
    check_log(name, exp[15:8], exp[7:0]);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx_dv = 1'b0; rx_byte = 8'h00;
    rsp_valid = 1'b0; rsp_data = 8'h00; rsp_err = 1'b0;
    tx_hold = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (state !== 4'd0 || busy !== 1'b0 || req !== 1'b0 || tx_dv !== 1'b0 || drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: state %0d busy %b req %b txdv %b drop %b, expected all 0",
               state, busy, req, tx_dv, drop);
    end
    checks++;
    if (tx_byte !== 8'h00 || req_cmd !== 8'h00 || req_addr !== 5'h00) begin
      errors++;
      $display("FAIL reset_data: tx_byte %02h req_cmd %02h req_addr %02h, expected 0",
               tx_byte, req_cmd, req_addr);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_valid_read;
    tx_log.delete();
    send_byte(8'h01);
    send_byte(8'h05);
    @(negedge clk);
    checks++;
    if (state !== 4'd2 || req !== 1'b0) begin
      errors++;
      $display("FAIL valid_check_cycle: state %0d req %b expected 2 0", state, req);
    end
    @(negedge clk);
    checks++;
    if (req !== 1'b1 || state !== 4'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL valid_req_latency: req %b state %0d busy %b expected 1 3 1", req, state, busy);
    end
    checks++;
    if (req_addr !== 5'd5 || req_cmd !== 8'h01) begin
      errors++;
      $display("FAIL valid_req_fields: addr %0d cmd %02h expected 5 01", req_addr, req_cmd);
    end
    pulse_rsp(3, 1'b0, 8'h1A);
    wait_done(2, "valid");
    check_log("valid", 8'h81, 8'h1A);
    checks++;
    if (req !== 1'b0) begin
      errors++;
      $display("FAIL valid_req_release: req %b expected 0", req);
    end
  endtask

  task automatic test_bad_cmd;
    int r0;
    r0 = req_rises;
    tx_log.delete();
    send_byte(8'h09);
    send_byte(8'h00);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (tx_dv !== 1'b1 || tx_byte !== 8'hE0) begin
      errors++;
      $display("FAIL bad_cmd_latency: txdv %b byte %02h expected 1 E0", tx_dv, tx_byte);
    end
    wait_done(2, "bad_cmd");
    check_log("bad_cmd", 8'hE0, 8'h09);
    checks++;
    if (req_rises !== r0) begin
      errors++;
      $display("FAIL bad_cmd_noreq: %0d request pulses expected 0", req_rises - r0);
    end
  endtask

  task automatic test_rsp_timeout;
    bit seen;
    tx_log.delete();
    send_byte(8'h04);
    send_byte(8'h0A);
    wait_req(seen);
    wait_done(2, "timeout");
    check_log("timeout", 8'hE3, 8'h00);
    checks++;
    if (!seen || req_fall - req_rise != 100) begin
      errors++;
      $display("FAIL timeout_req_width: seen %0b width %0d expected 100", seen, req_fall - req_rise);
    end
    tx_log.delete();
    send_byte(8'h05);
    send_byte(8'h11);
    wait_req(seen);
    if (seen) pulse_rsp(98, 1'b0, 8'h5C);
    wait_done(2, "rsp_at_limit");
    check_log("rsp_at_limit", 8'h85, 8'h5C);
    checks++;
    if (!seen || req_fall - req_rise != 100) begin
      errors++;
      $display("FAIL rsp_at_limit_width: seen %0b width %0d expected 100", seen, req_fall - req_rise);
    end
  endtask

  task automatic test_frame_timeout;
    int r0;
    r0 = req_rises;
    tx_log.delete();
    send_byte(8'h01);
    repeat (50) @(negedge clk);
    checks++;
    if (state !== 4'd1) begin
      errors++;
      $display("FAIL frame_before_limit: state %0d expected 1", state);
    end
    @(negedge clk);
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL frame_at_limit: state %0d expected 0", state);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (tx_log.size() != 0 || req_rises !== r0) begin
      errors++;
      $display("FAIL frame_silent: %0d bytes %0d requests expected 0 0",
               tx_log.size(), req_rises - r0);
    end
    run_frame("after_frame_to", 8'h01, 8'h05, 0, 8'h1A, 2, 0);
  endtask

  task automatic test_drop;
    bit seen;
    int d0;
    int k;
    tx_len = 8;
    tx_log.delete();
    send_byte(8'h02);
    send_byte(8'h03);
    wait_req(seen);
    if (seen) pulse_rsp(0, 1'b0, 8'h77);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (state == 4'd6) break;
    end
    d0 = drop_cnt;
    send_byte(8'hAA);
    @(negedge clk);
    checks++;
    if (drop !== 1'b1) begin
      errors++;
      $display("FAIL drop_pulse: drop %b expected 1 (state seen %0d)", drop, state);
    end
    wait_done(2, "drop");
    check_log("drop", 8'h82, 8'h77);
    checks++;
    if (drop_cnt - d0 != 1) begin
      errors++;
      $display("FAIL drop_count: %0d pulses expected 1", drop_cnt - d0);
    end
    tx_len = 3;
  endtask

  task automatic test_tx_active_wait;
    tx_hold = 1'b1;
    tx_log.delete();
    send_byte(8'h07);
    send_byte(8'h00);
    repeat (6) @(negedge clk);
    checks++;
    if (tx_log.size() != 0 || state !== 4'd5) begin
      errors++;
      $display("FAIL active_hold: %0d bytes state %0d expected 0 bytes state 5",
               tx_log.size(), state);
    end
    tx_hold = 1'b0;
    wait_done(2, "active_wait");
    check_log("active_wait", 8'hE0, 8'h07);
  endtask

  task automatic test_reset_mid;
    bit seen;
    tx_log.delete();
    send_byte(8'h01);
    send_byte(8'h02);
    wait_req(seen);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (req !== 1'b0 || state !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: req %b state %0d busy %b expected 0 0 0", req, state, busy);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (tx_log.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_notx: %0d bytes expected 0", tx_log.size());
    end
    run_frame("post_reset", 8'h03, 8'h07, 0, 8'h3C, 1, 0);
  endtask

  task automatic test_back_to_back;
    logic [7:0] c, a, data;
    int kind, r;
    for (int i = 0; i < 30; i++) begin
      c = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(7, 255)) : 8'($urandom_range(0, 6));
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
      r = $urandom_range(0, 9);
      kind = (r < 6) ? 0 : ((r < 9) ? 1 : 2);
      data = 8'($urandom);
      tx_len = $urandom_range(1, 5);
      run_frame("rand", c, a, kind, data, $urandom_range(0, 30), $urandom_range(0, 5));
    end
    tx_len = 3;
  endtask

  initial begin
    test_reset();
    test_valid_read();
    test_bad_cmd();
    run_frame("bad_addr", 8'h02, 8'h40, 0, 8'h00, 0, 0);
    run_frame("sensor_err", 8'h03, 8'h1F, 1, 8'h55, 4, 1);
    test_rsp_timeout();
    test_frame_timeout();
    test_drop();
    test_tx_active_wait();
    test_reset_mid();
    test_back_to_back();
    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_handler.md
UART_CMD_HANDLER -- requirements
Module: uart_cmd_handler

Interface
REQ-001 SHALL have parameter FRAME_TIMEOUT, default 52080, meaning max clocks between command byte and address byte (10 bit-times at 5208 clks/bit).
REQ-002 SHALL have parameter RSP_TIMEOUT, default 50000000, meaning max clocks waiting for sensor response (1 s at 50 MHz).
REQ-003 SHALL have parameter MAX_CMD, default 8'h06, meaning highest valid command code.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port i_Clock  in  1  system clock, all logic on rising edge.
REQ-006 SHALL have port i_Rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port i_Rx_DV  in  1  one-cycle pulse, received byte valid.
REQ-008 SHALL have port i_Rx_Byte  in  8  received byte, valid when i_Rx_DV=1.
REQ-009 SHALL have port o_Tx_DV  out  1  one-cycle pulse requesting transmission of o_Tx_Byte.
REQ-010 SHALL have port o_Tx_Byte  out  8  byte to transmit.
REQ-011 SHALL have port i_Tx_Active  in  1  transmitter busy.
REQ-012 SHALL have port i_Tx_Done  in  1  one-cycle pulse, byte transmission finished.
REQ-013 SHALL have port o_Req  out  1  level sensor request.
REQ-014 SHALL have port o_Req_Cmd  out  8  command forwarded to sensor side.
REQ-015 SHALL have port o_Req_Addr  out  5  sensor address 0..31.
REQ-016 SHALL have port i_Rsp_Valid  in  1  one-cycle pulse, sensor response ready.
REQ-017 SHALL have port i_Rsp_Data  in  8  sensor data, valid with i_Rsp_Valid.
REQ-018 SHALL have port i_Rsp_Err  in  1  sensor fault flag, valid with i_Rsp_Valid.
REQ-019 SHALL have port o_Busy  out  1  high in every state except IDLE and GET_ADDR.
REQ-020 SHALL have port o_Drop  out  1  one-cycle pulse when a received byte is discarded.
REQ-021 SHALL have port o_State  out  4  current state encoding, for debug LEDs.

Function
REQ-022 States SHALL be IDLE=0, GET_ADDR=1, CHECK=2, REQ=3, WAIT_RSP=4, SEND0=5, WAIT0=6, SEND1=7, WAIT1=8.
REQ-023 IDLE: i_Rx_DV latches command byte, go to GET_ADDR.
REQ-024 GET_ADDR: i_Rx_DV latches address byte, go to CHECK; frame counter cleared on entry, and at FRAME_TIMEOUT clocks without a byte -> IDLE, no response.
REQ-025 CHECK (one cycle): cmd>MAX_CMD -> response {8'hE0, cmd}; else addr[7:5]!=0 -> {8'hE1, addr}; else -> REQ; error paths go to SEND0.
REQ-026 REQ: assert o_Req, o_Req_Cmd=cmd, o_Req_Addr=addr[4:0], go to WAIT_RSP; o_Req held high through WAIT_RSP.
REQ-027 WAIT_RSP: i_Rsp_Valid with i_Rsp_Err=0 -> response {8'h80|cmd, i_Rsp_Data}; with i_Rsp_Err=1 -> {8'hE2, 8'h00}; o_Req deasserts next cycle.
REQ-028 WAIT_RSP: RSP_TIMEOUT clocks elapsed -> response {8'hE3, 8'h00}, o_Req deasserts; i_Rsp_Valid on the timeout cycle SHALL win over timeout.
REQ-029 SEND0/SEND1: wait while i_Tx_Active=1; then pulse o_Tx_DV one cycle with byte0/byte1 on o_Tx_Byte, go to WAIT0/WAIT1.
REQ-030 o_Tx_Byte SHALL be stable from the o_Tx_DV cycle until i_Tx_Done.
REQ-031 WAIT0: i_Tx_Done -> SEND1; WAIT1: i_Tx_Done -> IDLE.
REQ-032 i_Rx_DV in any state with o_Busy=1 SHALL be ignored and pulse o_Drop in the following cycle.
REQ-033 Latency: address byte at cycle N -> CHECK at N+1 -> o_Req high (or error o_Tx_DV if i_Tx_Active=0) at N+2.
REQ-034 Timeout counters SHALL saturate, never wrap, and be wide enough for the parameter values.

Reset
REQ-035 While i_Rst_n=0: state IDLE; o_Tx_DV, o_Req, o_Busy, o_Drop=0; o_Tx_Byte, o_Req_Cmd, o_Req_Addr=8'h00/5'h00; o_State=0; counters and latched bytes cleared.
REQ-036 Reset asserted mid-operation SHALL abort immediately without emitting further o_Tx_DV; first byte after release is treated as a command.

Verification
REQ-037 Bytes 8'h01, 8'h05; sensor replies valid, data 8'h1A -> o_Req_Addr=5, o_Req_Cmd=1; Tx bytes 8'h81 then 8'h1A, one o_Tx_DV each.
REQ-038 Bytes 8'h09, 8'h00 -> no o_Req; Tx 8'hE0, 8'h09.
REQ-039 Bytes 8'h02, 8'h40 -> no o_Req; Tx 8'hE1, 8'h40.
REQ-040 RSP_TIMEOUT=100, no sensor reply -> o_Req falls 100 clocks after rising; Tx 8'hE3, 8'h00; also i_Rsp_Valid on cycle 100 -> data response instead.
REQ-041 FRAME_TIMEOUT=50, single byte 8'h01 then silence -> return to IDLE at clock 50, no Tx; next pair processed normally.
REQ-042 Byte arrives during WAIT0 -> o_Drop pulse, response bytes unchanged; reset during WAIT_RSP -> o_Req=0 asynchronously, no Tx.
